// File: rtl/sum_block_accumulator.sv
// Accumulates COUNT consecutive adder-stage sums into one saturated block total,
// with valid/ready on both sides, a sticky overflow flag and an early-flush input.
module sum_block_accumulator #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 16,
    parameter int COUNT  = 4,
    parameter int CNT_W  = $clog2(COUNT + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf,
    output logic              busy
);

    localparam int SUM_W = ACC_W + 1;

    typedef enum logic {ACCUM, HOLD} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ACC_W-1:0]  acc;
    logic [CNT_W-1:0]  cnt;
    logic              ovf;

    logic              accept;
    logic [SUM_W-1:0]  add_res;
    logic [ACC_W-1:0]  acc_add;
    logic [CNT_W-1:0]  cnt_add;
    logic              ovf_add;
    logic              emit;

    // Top bit of the result flags saturation; the low ACC_W bits are the clamped sum.
    function automatic logic [SUM_W-1:0] sat_add(input logic [ACC_W-1:0]  a,
                                                  input logic [DATA_W-1:0] d);
        logic [SUM_W-1:0] full;
        full = {1'b0, a} + SUM_W'(d);
        if (full[ACC_W]) begin
            sat_add = {1'b1, {ACC_W{1'b1}}};
        end else begin
            sat_add = full;
        end
    endfunction

    assign accept  = in_valid && in_ready;
    assign add_res = sat_add(acc, in_data);
    assign acc_add = add_res[ACC_W-1:0];
    assign ovf_add = ovf | add_res[ACC_W];
    assign cnt_add = cnt + CNT_W'(1);

    // A block closes when it fills, or on flush provided it holds at least one sample.
    assign emit = (state == ACCUM) &&
                  ((accept && ((cnt_add == CNT_W'(COUNT)) || flush)) ||
                   (!accept && flush && (cnt != '0)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACCUM;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ACCUM:   if (emit) state_nxt = HOLD;
            HOLD:    if (out_ready) state_nxt = ACCUM;
            default: state_nxt = ACCUM;
        endcase
    end

    always_comb begin
        in_ready  = (state == ACCUM);
        out_valid = (state == HOLD);
        busy      = (cnt != '0) || (state == HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            out_sum   <= '0;
            out_count <= '0;
            out_ovf   <= 1'b0;
        end else if (state == ACCUM) begin
            if (accept) begin
                acc <= acc_add;
                cnt <= cnt_add;
                ovf <= ovf_add;
            end
            if (emit) begin
                out_sum   <= accept ? acc_add : acc;
                out_count <= accept ? cnt_add : cnt;
                out_ovf   <= accept ? ovf_add : ovf;
            end
        end else if (out_ready) begin
            // Result taken: the next block starts from a clean slate.
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
        end
    end

endmodule

// File: doc/sum_block_accumulator.md
Name: sum_block_accumulator

Overview:
- Downstream consumer of the 8-bit combinational adder stage: takes the stream of 8-bit sums it produces and accumulates COUNT consecutive sums into one wider block total.
- Input and output both use valid/ready handshakes. The output feeds result capture or the checking logic.
- Saturating arithmetic with a sticky overflow flag.
- A flush input emits a partial block early.

Parameters:
- DATA_W, 8, width of each incoming sum.
- ACC_W, 16, accumulator and output width; must be >= DATA_W.
- COUNT, 4, sums per block; must be >= 1.
- CNT_W, $clog2(COUNT+1), width of the sample counter and out_count.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  in_data is valid this cycle
- in_ready  output  1  block can accept in_data this cycle
- in_data  input  DATA_W  unsigned sum from the adder stage
- flush  input  1  single-cycle request to close the current block early
- out_valid  output  1  block result is available
- out_ready  input  1  consumer accepts the result
- out_sum  output  ACC_W  block total, saturated to 2^ACC_W-1
- out_count  output  CNT_W  number of samples in this result, 1..COUNT
- out_ovf  output  1  saturation occurred in this block
- busy  output  1  high when cnt != 0 or out_valid

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=ACCUM, acc=0, cnt=0, ovf=0.
  - out_valid=0, out_sum=0, out_count=0, out_ovf=0, busy=0.
  - in_ready=1 on the first clock after release.
- State ACCUM:
  - in_ready=1; out_valid=0.
  - Accept when in_valid&&in_ready.
  - On accept: acc <= sat(acc + zero-extended in_data); cnt <= cnt+1.
  - sat: if the true sum > 2^ACC_W-1, acc <= 2^ACC_W-1 and ovf <= 1 (sticky until the block is emitted).
  - When the accept makes cnt reach COUNT: in the same edge, latch out_sum/out_count/out_ovf from the post-add values and go to HOLD. out_valid is high the next cycle, i.e. 1-cycle latency from the final accept.
- Flush in ACCUM:
  - flush with cnt>0 and no accept: emit current acc/cnt/ovf, go to HOLD.
  - flush in the same cycle as an accept: the sample is included first, then the block is emitted with cnt+1 (even if cnt+1 < COUNT).
  - flush with cnt==0 and no accept: ignored; no empty blocks are ever emitted.
- State HOLD:
  - in_ready=0; out_valid=1.
  - out_sum/out_count/out_ovf are held stable until handshake.
  - flush is ignored in HOLD.
  - On out_valid&&out_ready: acc=0, cnt=0, ovf=0, state=ACCUM.
  - out_valid falls the cycle after the handshake; in_ready rises the same cycle.
  - No same-cycle pass-through: one bubble cycle per block. Maximum throughput is COUNT samples per COUNT+1 cycles.
- Backpressure: out_ready low holds HOLD indefinitely. Upstream stalls via in_ready=0; no sample is lost or duplicated.
- in_data is ignored when in_valid=0 or in_ready=0.
- Reset mid-block or in HOLD: partial acc and any pending result are discarded immediately; outputs return to reset values asynchronously.
- COUNT=1: every accepted sample emits a block with out_count=1.
- All outputs are registered; no combinational path from in_valid or out_ready to any output except through state.

Test Plan:
- Basic block: COUNT=4; 4 back-to-back samples of 6 (4+2), out_ready=1.
  -> out_valid one cycle after the 4th accept; out_sum=24, out_count=4, out_ovf=0; in_ready low exactly one cycle.
- Backpressure: samples 10,20,30,40 with out_ready=0 for 5 cycles, then 1.
  -> out_sum=100 held stable for all HOLD cycles; in_ready=0 throughout; a 5th sample offered during HOLD is accepted only after the handshake and starts a new block.
- Saturation: ACC_W=9; 4 samples of 255.
  -> out_sum=511, out_ovf=1. The next block of 1,1,1,1 gives out_sum=4, out_ovf=0 (sticky flag cleared).
- Flush cases:
  - samples 7,9, then flush alone -> out_sum=16, out_count=2.
  - flush coincident with a 3rd sample 5 in a fresh block -> out_sum=5 included, out_count=3 (after two prior samples 1,1 -> out_sum=7).
  - flush with an empty block -> no output.
- Reset mid-operation: 2 samples accepted, rst_n pulled low mid-cycle.
  -> busy/out_valid drop immediately. After release, 4 samples of 3 -> out_sum=12 (no residue).
- Random stress: random in_valid/out_ready/flush over 2000 cycles against a reference model.
  -> every out_sum equals the saturated sum of its samples; the total of out_count equals the total accepted samples.
